// File: rtl/i2c_sub_regfile.sv
// Byte-addressed register file behind the I2C subordinate, with a local host port.
// Define I2C_REGFILE_AUTOINC_EN to auto-increment the pointer after each data byte / tx_req.
module i2c_sub_regfile #(
    parameter  int NUM_REGS = 16,
    localparam int PW       = $clog2(NUM_REGS)
) (
    input  logic          clk_400,
    input  logic          rst,
    input  logic          txn_start,
    input  logic          txn_rw,
    input  logic          txn_stop,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_req,
    input  logic          host_we,
    input  logic [PW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic          collision,
    output logic [PW-1:0] ptr_out
);
    typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    tx_data_q, host_rdata_q;
    logic          wr_strobe_q, collision_q;
    logic [PW-1:0] wr_addr_q;
    logic          host_hit_d;

    // Power-of-two depth, so the natural PW-bit overflow is the wrap.
    function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p);
`ifdef I2C_REGFILE_AUTOINC_EN
        return PW'(p + 1'b1);
`else
        return p;
`endif
    endfunction

    assign host_hit_d = host_we && (host_addr == ptr_q);

    always_ff @(posedge clk_400) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            tx_data_q    <= 8'h00;
            host_rdata_q <= 8'h00;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            collision_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            wr_strobe_q <= 1'b0;
            // A START wins over everything; rx_valid in that cycle is dropped.
            if (txn_start) begin
                state_q <= txn_rw ? RDATA : PTR;
            end else begin
                case (state_q)
                    PTR: if (rx_valid) begin
                        ptr_q   <= rx_data[PW-1:0];
                        state_q <= WDATA;
                    end
                    WDATA: if (rx_valid) begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= ptr_q;
                        ptr_q       <= ptr_adv(ptr_q);
                        if (host_hit_d) collision_q <= 1'b1;
                        else            regs_q[ptr_q] <= rx_data;
                    end
                    RDATA: if (tx_req) ptr_q <= ptr_adv(ptr_q);
                    default: ;
                endcase
                if (txn_stop) state_q <= IDLE;
            end
            if (host_we) regs_q[host_addr] <= host_wdata;
            tx_data_q    <= regs_q[ptr_q];
            host_rdata_q <= regs_q[host_addr];
        end
    end

    assign tx_data    = tx_data_q;
    assign host_rdata = host_rdata_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign collision  = collision_q;
    assign ptr_out    = ptr_q;
endmodule

// File: tb/tb_i2c_sub_regfile.sv
// Directed bench for i2c_sub_regfile; expected values follow I2C_REGFILE_AUTOINC_EN.
module tb_i2c_sub_regfile;
    localparam int NUM_REGS = 16;
    localparam int PW = $clog2(NUM_REGS);
`ifdef I2C_REGFILE_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic          clk_400 = 1'b0;
    logic          rst = 1'b1;
    logic          txn_start = 1'b0, txn_rw = 1'b0, txn_stop = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_req = 1'b0;
    logic          host_we = 1'b0;
    logic [PW-1:0] host_addr = '0;
    logic [7:0]    host_wdata = 8'h00;
    logic [7:0]    host_rdata;
    logic          wr_strobe;
    logic [PW-1:0] wr_addr;
    logic          collision;
    logic [PW-1:0] ptr_out;

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] m_ptr = '0;

    i2c_sub_regfile #(.NUM_REGS(NUM_REGS)) dut (
        .clk_400(clk_400), .rst(rst),
        .txn_start(txn_start), .txn_rw(txn_rw), .txn_stop(txn_stop),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .collision(collision), .ptr_out(ptr_out)
    );

    always #5 clk_400 = ~clk_400;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_400);
        #1;
    endtask

    task automatic start(input logic rw);
        txn_start = 1'b1; txn_rw = rw; tick(); txn_start = 1'b0;
    endtask

    task automatic stop();
        txn_stop = 1'b1; tick(); txn_stop = 1'b0;
    endtask

    task automatic rx_ptr(input logic [7:0] b);
        m_ptr = b[PW-1:0];
        rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    endtask

    task automatic rx_dat(input logic [7:0] b);
        exp_q.push_back(m_ptr);
        m_ptr = PW'(m_ptr + AI);
        rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    endtask

    task automatic hwrite(input logic [PW-1:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d; tick(); host_we = 1'b0;
    endtask

    task automatic hread(input string tag, input logic [PW-1:0] a, input logic [7:0] exp);
        host_addr = a; tick();
        check(tag, host_rdata, exp);
    endtask

    // Scoreboard: every wr_strobe must match the next queued commit address.
    always @(posedge clk_400) begin
        #1;
        if (wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) check("wr_unexpected", wr_strobe, 0);
            else check("wr_addr", wr_addr, exp_q.pop_front());
        end
    end

    initial begin
        // Reset
        tick(); tick(); rst = 1'b0;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_host_rdata", host_rdata, 8'h00);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_collision", collision, 0);
        check("rst_ptr", ptr_out, 0);
        for (int i = 0; i < NUM_REGS; i++) hread($sformatf("rst_reg%0d", i), PW'(i), 8'h00);

        // I2C write burst
        start(1'b0); rx_ptr(8'h03); rx_dat(8'hAB); rx_dat(8'hCD); stop();
        check("wr_ptr", ptr_out, AI ? 5 : 3);
        hread("wr_reg3", 4'd3, AI ? 8'hAB : 8'hCD);
        hread("wr_reg4", 4'd4, AI ? 8'hCD : 8'h00);

        // rx_valid in IDLE is ignored
        rx_data = 8'hEE; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        check("idle_rx_nostrobe", wr_strobe, 0);
        check("idle_rx_ptr", ptr_out, AI ? 5 : 3);

        // Read with wrap
        hwrite(4'd15, 8'hC3); hwrite(4'd0, 8'h5A);
        start(1'b0); rx_ptr(8'h0F); stop();
        start(1'b1); tick();
        check("rd_tx0", tx_data, 8'hC3);
        tx_req = 1'b1; tick(); tx_req = 1'b0; tick();
        check("rd_tx1", tx_data, AI ? 8'h5A : 8'hC3);
        check("rd_ptr1", ptr_out, AI ? 0 : 15);
        tx_req = 1'b1; tick(); tx_req = 1'b0;
        check("rd_ptr2", ptr_out, AI ? 1 : 15);
        stop();

        // Pointer upper bits ignored
        start(1'b0); rx_ptr(8'h12); rx_dat(8'h77); stop();
        hread("ub_reg2", 4'd2, 8'h77);
        check("ub_ptr", ptr_out, AI ? 3 : 2);

        // Collision: host wins, strobe still pulses, flag sticky
        start(1'b0); rx_ptr(8'h04);
        host_we = 1'b1; host_addr = 4'd4; host_wdata = 8'h11;
        rx_dat(8'h22); host_we = 1'b0;
        check("col_flag", collision, 1);
        hread("col_reg4", 4'd4, 8'h11);
        stop();
        // Different indices in the same cycle both commit
        start(1'b0); rx_ptr(8'h08);
        host_we = 1'b1; host_addr = 4'd9; host_wdata = 8'h44;
        rx_dat(8'h33); host_we = 1'b0;
        stop();
        hread("dual_reg8", 4'd8, 8'h33);
        hread("dual_reg9", 4'd9, 8'h44);
        tick(); tick();
        check("col_sticky", collision, 1);

        // Repeated bytes to pointer 6
        start(1'b0); rx_ptr(8'h06); rx_dat(8'h01); rx_dat(8'h02); stop();
        hread("rep_reg6", 4'd6, AI ? 8'h01 : 8'h02);
        hread("rep_reg7", 4'd7, AI ? 8'h02 : 8'h00);
        check("rep_ptr", ptr_out, AI ? 8 : 6);

        // Repeated START from WDATA behaves as from IDLE
        start(1'b0); rx_ptr(8'h0A); start(1'b1); tick();
        check("rs_tx", tx_data, 8'h00);
        rx_data = 8'h99; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        check("rs_rx_ignored", wr_strobe, 0);
        stop();

        // Reset clears collision and pointer
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_collision", collision, 0);
        check("rst2_ptr", ptr_out, 0);
        hread("rst2_reg6", 4'd6, 8'h00);

        tick();
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
